// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaler and time-multiplexed digit scan.
// Define HEX_MODE_EN to make every digit count 0..F instead of 0..9.
module bcd_scan_counter #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned SCAN_DIV = 2,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  output logic [3:0]            digit_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   value_bcd,
  output logic                  carry_out
);

`ifdef HEX_MODE_EN
  localparam logic [3:0] DMAX = 4'hF;
`else
  localparam logic [3:0] DMAX = 4'd9;
`endif

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]          presc_q, presc_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    cnt_q, cnt_d;
  logic                   carry_q, carry_d;
  logic [DIGITS-1:0]      sel_q, sel_d;
  logic [3:0]             out_q, out_d;

  logic                   tick;
  logic                   ripple;
  logic [3:0]             dig;
  logic [4*DIGITS-1:0]    cnt_step;

  // Prescaler: holds while disabled, restarts on clear.
  assign tick = en && !clear && (presc_q == PRE_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Digit-serial ripple: each digit moves only while every lower digit wrapped;
  // ripple surviving past the top digit marks a full-counter wrap.
  always_comb begin
    cnt_step = cnt_q;
    ripple   = 1'b1;
    dig      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (ripple) begin
        if (up_dn) begin
          if (dig == DMAX) begin
            cnt_step[4*i +: 4] = '0;
          end else begin
            cnt_step[4*i +: 4] = dig + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            cnt_step[4*i +: 4] = DMAX;
          end else begin
            cnt_step[4*i +: 4] = dig - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d   = cnt_step;
      carry_d = ripple;
    end
  end

  // Scan runs regardless of en/clear.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Select and nibble both derive from idx_d so they always change together.
  always_comb begin
    sel_d = '0;
    out_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        sel_d[i] = 1'b1;
        out_d    = cnt_q[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sel_q   <= DIGITS'(1);
      out_q   <= '0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
    end
  end

  assign digit_out = out_q;
  assign digit_sel = sel_q;
  assign value_bcd = cnt_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: integer reference model feeds a queue,
// a negedge monitor pops and compares every cycle.
module tb_bcd_scan_counter;

  localparam int unsigned P = 4;
  localparam int unsigned S = 2;
  localparam int unsigned D = 4;
`ifdef HEX_MODE_EN
  localparam int BASE = 16;
  localparam logic [15:0] AFTER40 = 16'h000A;
  localparam logic [15:0] ALLMAX  = 16'hFFFF;
`else
  localparam int BASE = 10;
  localparam logic [15:0] AFTER40 = 16'h0010;
  localparam logic [15:0] ALLMAX  = 16'h9999;
`endif
  localparam int MODV = BASE ** D;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           up_dn = 1'b1;
  logic           clear = 1'b0;
  logic [3:0]     digit_out;
  logic [D-1:0]   digit_sel;
  logic [4*D-1:0] value_bcd;
  logic           carry_out;

  bcd_scan_counter #(.PRESCALE(P), .SCAN_DIV(S), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
    .digit_out(digit_out), .digit_sel(digit_sel),
    .value_bcd(value_bcd), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*D-1:0] val;
    logic           carry;
    logic [D-1:0]   sel;
    logic [3:0]     out;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int carry_seen = 0;

  // Reference model: counter as a plain integer modulo BASE**D, elapsed cycles for scan.
  int m_val = 0;
  int m_pre = 0;
  int m_cyc = 0;

  function automatic logic [4*D-1:0] to_nibbles(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < int'(D); i++) begin
      r[4*i +: 4] = 4'(v % BASE);
      v = v / BASE;
    end
    return r;
  endfunction

  function automatic int digit_of(input int v, input int k);
    for (int i = 0; i < k; i++) v = v / BASE;
    return v % BASE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    logic [D-1:0] one;
    int idx;
    @(posedge clk);
    one = 1;
    m_cyc++;
    idx = (m_cyc / int'(S)) % int'(D);
    e.sel = one << idx;
    e.out = 4'(digit_of(m_val, idx));
    e.carry = 1'b0;
    if (clear) begin
      m_val = 0;
      m_pre = 0;
    end else if (en) begin
      if (m_pre == int'(P) - 1) begin
        m_pre = 0;
        if (up_dn) begin
          if (m_val == MODV - 1) e.carry = 1'b1;
          m_val = (m_val + 1) % MODV;
        end else begin
          if (m_val == 0) e.carry = 1'b1;
          m_val = (m_val + MODV - 1) % MODV;
        end
      end else begin
        m_pre++;
      end
    end
    e.val = to_nibbles(m_val);
    q.push_back(e);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_value"}, 32'(value_bcd), 32'h0);
    chk({tag, "_sel"},   32'(digit_sel), 32'h1);
    chk({tag, "_out"},   32'(digit_out), 32'h0);
    chk({tag, "_carry"}, 32'(carry_out), 32'h0);
  endtask

  // Called right after step(): lands mid-cycle, after the monitor has drained the queue.
  task automatic do_reset();
    #6;
    rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    m_val = 0;
    m_pre = 0;
    m_cyc = 0;
  endtask

  always @(negedge clk) begin
    if (carry_out === 1'b1) carry_seen++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_value", 32'(value_bcd), 32'(e.val));
      chk("sb_carry", 32'(carry_out), 32'(e.carry));
      chk("sb_sel",   32'(digit_sel), 32'(e.sel));
      chk("sb_out",   32'(digit_out), 32'(e.out));
    end
  end

  initial begin
    #12;
    check_reset_state("init_rst");
    #1;
    rst = 1'b1;

    en = 1'b1;
    up_dn = 1'b1;
    carry_seen = 0;
    repeat (40) step();
    chk("up40_value", 32'(value_bcd), 32'(AFTER40));
    chk("up40_carries", 32'(carry_seen), 32'd0);

    do_reset();
    carry_seen = 0;
    en = 1'b1;
    up_dn = 1'b0;
    repeat (P) step();
    chk("down_wrap_value", 32'(value_bcd), 32'(ALLMAX));
    repeat (P) step();
    chk("down_wrap_pulses", 32'(carry_seen), 32'd1);
    up_dn = 1'b1;
    for (int n = 0; n < 20 && value_bcd != 16'h0; n++) step();
    chk("up_wrap_value", 32'(value_bcd), 32'h0);
    repeat (2) step();
    chk("up_wrap_pulses", 32'(carry_seen), 32'd2);

    do_reset();
    en = 1'b1;
    up_dn = 1'b1;
    for (int n = 0; n < 4000 && value_bcd != 16'h0123; n++) step();
    chk("reach_0123", 32'(value_bcd), 32'h0123);
    for (int n = 0; n < 10 && m_pre != int'(P) - 1; n++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_value", 32'(value_bcd), 32'h0);
    chk("clear_carry", 32'(carry_out), 32'h0);
    repeat (P) step();
    chk("tick_after_clear", 32'(value_bcd), 32'h1);
    en = 1'b0;
    repeat (20) step();
    chk("frozen_value", 32'(value_bcd), 32'h1);

    do_reset();
    en = 1'b1;
    up_dn = 1'b1;
    for (int n = 0; n < 90000 && value_bcd != 16'h4321; n++) step();
    chk("reach_4321", 32'(value_bcd), 32'h4321);
    en = 1'b0;
    repeat (4 * S * D) step();
    chk("scan_frozen", 32'(value_bcd), 32'h4321);

    for (int n = 0; n < 3000; n++) begin
      en    = ($urandom_range(0, 3) != 0);
      up_dn = ($urandom_range(0, 1) == 1);
      clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end
    clear = 1'b0;
    en = 1'b0;
    up_dn = 1'b0;
    m_pre = m_pre;
    for (int n = 0; n < 6; n++) step();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Upstream stage of the 7-segment decoder.
- Holds a multi-digit up/down counter with a prescaler. Digits are BCD by default.
- Time-multiplexes the digits into a single 4-bit nibble, plus a one-hot digit select, for the decoder and the digit drivers.
- The nibble drives the decoder's BCD/hex input bits directly.

Parameters:
PRESCALE, 4, enabled clk cycles per count tick; legal range >=1.
SCAN_DIV, 2, clk cycles each digit stays selected; legal range >=1.
DIGITS, 4, number of counter digits; legal range 1..8.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset (rst=0 resets).
en  input  1  count enable; gates prescaler and counter, not scanning.
up_dn  input  1  1=count up, 0=count down; sampled on tick.
clear  input  1  synchronous clear of counter and prescaler.
digit_out  output  4  value of the currently selected digit, registered.
digit_sel  output  DIGITS  one-hot select, bit i = digit i (digit 0 = least significant), registered.
value_bcd  output  4*DIGITS  full counter value, digit i at bits [4i+3:4i].
carry_out  output  1  one-cycle pulse on counter wrap (up or down).

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler=0, scan counter=0, digit index=0.
  - value_bcd=0, digit_out=0, digit_sel=1 (digit 0), carry_out=0.
- Prescaler:
  - While en=1, counts 0..PRESCALE-1.
  - When it equals PRESCALE-1, that cycle asserts internal tick and the prescaler wraps to 0.
  - en=0 holds the prescaler. PRESCALE=1 means a tick on every enabled cycle.
- Counter update on tick (visible on value_bcd the cycle after the tick):
  - up_dn=1: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - up_dn=0: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - Wrap: all-9s up -> all-0s, and all-0s down -> all-9s. Either wrap sets carry_out=1 for exactly one cycle, aligned with the new value_bcd.
  - carry_out=0 at all other times.
- Priority and simultaneous events:
  - clear=1 zeroes value_bcd and the prescaler and suppresses any same-cycle tick; carry_out=0 that cycle. clear overrides en.
  - An up_dn change is sampled only on tick. Mid-prescale changes neither reset nor disturb the prescaler.
- Scanning:
  - Free-running; independent of en and clear.
  - Scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances i -> i+1, with DIGITS-1 -> 0.
  - digit_sel and digit_out are registered together, so they always change in the same cycle.
  - digit_out = digit[index] as of the previous cycle's counter state (one-cycle latency relative to value_bcd).
  - A digit is never shown with another digit's select.
- Reset asserted mid-operation: all state returns to reset values immediately, with no partial tick. Counting restarts from 0 after rst deasserts.

Optional Feature:
- Macro HEX_MODE_EN.
- Defined: each digit counts 0..F instead of 0..9.
  - Up: F -> 0 with carry.
  - Down: 0 -> F with borrow.
  - Wrap is all-F <-> all-0, with carry_out behaving the same way.
- Undefined: BCD as specified above. Nibble values A..F never occur on value_bcd or digit_out.

Test Plan (PRESCALE=4, SCAN_DIV=2, DIGITS=4 unless noted):
1. Reset: assert rst=0 asynchronously mid-cycle, then release -> immediately value_bcd=0x0000, digit_sel=4'b0001, digit_out=0, carry_out=0.
2. Up count: en=1, up_dn=1 for 40 cycles -> value_bcd reaches 0x0010 (ticks every 4 cycles, 9->0 carry into digit 1); no carry_out.
3. Down wrap: from 0x0000 set up_dn=0, en=1 -> after first tick value_bcd=0x9999 and carry_out pulses exactly 1 cycle. Preload 0x9999, up_dn=1 -> 0x0000 with one carry_out pulse.
4. Clear priority: clear=1 on the exact tick cycle with value 0x0123 -> next cycle value_bcd=0x0000, carry_out=0, prescaler restarts (next tick 4 cycles after clear drops). en=0 for 20 cycles -> value frozen.
5. Scan: value_bcd=0x4321, en=0 -> digit_sel cycles 0001,0010,0100,1000,0001 every 2 cycles with digit_out 1,2,3,4 matched in the same cycle; scanning continues while en=0.
6. HEX_MODE_EN defined: count up from 0x000E -> 0x000F -> 0x0010. Down from 0x0000 -> 0xFFFF with a carry_out pulse.
